// File: rtl/cdb_arbiter.sv
// Round-robin Common Data Bus arbiter: picks one completed functional-unit
// result per cycle and broadcasts its tag/value from registers on the next cycle.
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_grant,
  output logic                       cdb_valid,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [DATA_W-1:0]          cdb_data,
  output logic [$clog2(NUM_REQ)-1:0] cdb_src
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]  rr_ptr_q,    rr_ptr_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q,   cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q,  cdb_data_d;
  logic [PTR_W-1:0]  cdb_src_q,   cdb_src_d;

  logic              grant_found;
  logic              grant_ok;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W:0]    idx_sum;

  // Scan from rr_ptr upward with an explicit wrap so non-power-of-two
  // NUM_REQ never indexes a missing unit.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise the tool infers a latch to hold its old value.
    grant_found = 1'b0;
    grant_idx   = '0;
    idx_sum     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (idx_sum >= (PTR_W+1)'(NUM_REQ)) begin
        idx_sum = idx_sum - (PTR_W+1)'(NUM_REQ);
      end
      if (!grant_found && req_valid[idx_sum[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx_sum[PTR_W-1:0];
      end
    end
  end

  assign grant_ok = grant_found && !reset && !flush;

  always_comb begin
    req_grant = '0;
    if (grant_ok) begin
      req_grant[grant_idx] = 1'b1;
    end
  end

  // Without a grant the payload holds; only the valid bit drops.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = 1'b0;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    if (grant_ok) begin
      cdb_valid_d = 1'b1;
      cdb_tag_d   = req_tag[grant_idx*TAG_W +: TAG_W];
      cdb_data_d  = req_data[grant_idx*DATA_W +: DATA_W];
      cdb_src_d   = grant_idx;
      rr_ptr_d    = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before this edge, independent of order.
    if (reset) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;

endmodule
